encoder8_3_buffered: RTL and testbench
======================================

// Module: encoder8_3_buffered
// PURPOSE
//  Inverse of the register-select 3:8 decoder: turns a one-hot (or multi-hot)
//  8-bit vector back into a 3-bit select code, using the decoder's MSB-first map
//  (bit 7 -> 3'b000, bit i -> 3'(7-i)).
//  Valid/ready in, two-entry elastic buffer out. Reports write-port selects from
//  pipeline enable vectors back to the regfile/forwarding logic.
// PARAMETERS
//  SEL_W   3   select code width; input vector width is N = 2**SEL_W
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous reset, active-low
//  in_valid   in   1      in_vec is valid this cycle
//  in_ready   out  1      buffer can accept (transfer = in_valid & in_ready)
//  in_vec     in   N      vector to encode
//  out_valid  out  1      head entry valid
//  out_ready  in   1      consumer takes head (pop = out_valid & out_ready)
//  out_idx    out  SEL_W  encoded select code of head entry
//  out_hit    out  1      head vector had at least one bit set
//  out_multi  out  1      head vector had more than one bit set (see CONFIGURATION)
// BEHAVIOUR
//  Encode, combinational on in_vec before storage:
//   - highest set bit wins: idx = (N-1) - (index of highest set bit).
//   - in_vec = 0: idx = 0, hit = 0.
//  Storage: 2 entries {idx, hit, multi}. State machine: EMPTY, ONE, FULL.
//   - in_ready  = (state != FULL) & reset_n
//   - out_valid = (state != EMPTY)
//   - Outputs are driven only from registers; no combinational path from in_* to out_*.
//  State transitions:
//   - EMPTY: push -> ONE; new entry becomes head.
//   - ONE: push & no pop -> FULL; new entry goes to slot 2.
//   - ONE: pop & no push -> EMPTY.
//   - ONE: push & pop -> ONE; head is replaced by the new entry.
//   - FULL: no push (in_ready = 0); pop -> ONE; slot 2 moves to head.
//   - Any state with no push and no pop: hold.
//  Latency: an entry pushed at edge k is visible on out_* after edge k
//   (one cycle, EMPTY case). Full throughput of 1 entry/cycle while out_ready = 1.
//  Head stability: while out_valid = 1 and out_ready = 0, out_idx, out_hit and
//   out_multi hold stable.
//  Reset (async assert, sync release on clk):
//   - state = EMPTY; out_valid = 0, out_idx = 0, out_hit = 0, out_multi = 0.
//   - in_ready = 0 while reset_n = 0.
//   - Reset mid-transfer discards both entries; no partial pop.
//  Invalid head: out_idx, out_hit and out_multi are 0 whenever out_valid = 0.
// CONFIGURATION
//  ENC_MULTIHOT_CHECK_EN:
//   - Defined: multi = (popcount(in_vec) > 1), stored per entry and presented on
//     out_multi. out_idx still follows the highest-set-bit rule.
//   - Undefined: out_multi is tied to 0. No popcount logic is generated.
// TESTING
//  1. Reset, then in_vec=8'b1000_0000, out_ready=1 -> next cycle out_valid=1, out_idx=3'b000, out_hit=1.
//  2. Sweep one-hot bit i = 0..7 back-to-back, out_ready=1 -> out_idx = 7-i each cycle;
//     cascade with the 3:8 decoder round-trips all 8 codes.
//  3. out_ready=0, push 3 vectors (0x01, 0x04, 0x10) -> in_ready drops after the 2nd;
//     head holds idx=7. Raise out_ready -> idx 7 then 5 pop in order; the 3rd push is then accepted.
//  4. in_vec=8'h00 -> out_hit=0, out_idx=0. in_vec=8'b0010_0100 -> idx=2;
//     out_multi=1 if ENC_MULTIHOT_CHECK_EN is defined, else 0.
//  5. State ONE with simultaneous push (0x02) and pop -> stays ONE, next head idx=6, no entry lost.
//  6. reset_n low while FULL, mid-cycle (async) -> out_valid=0 immediately;
//     after release, in_ready=1 and state EMPTY.

Source files
------------

// File: rtl/encoder8_3_buffered_if.sv
// Handshake bundle for the buffered 8:3 encoder.
// The slave modport is the encoder; the master modport is the
// producer/consumer pair that drives vectors in and takes codes out.
interface encoder8_3_buffered_if #(
  parameter int SEL_W = 3
);
  localparam int N = 2 ** SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_idx;
  logic             out_hit;
  logic             out_multi;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_hit, out_multi
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_hit, out_multi
  );
endinterface

// File: rtl/encoder8_3_buffered.sv
// Buffered priority encoder: N-bit vector -> SEL_W-bit select code,
// MSB-first (bit N-1 -> 0, bit i -> N-1-i), highest set bit wins.
// Encoded entries sit in a two-entry elastic buffer; every out_* is a flop.
// Optional feature macro: ENC_MULTIHOT_CHECK_EN adds a per-entry
// "more than one bit set" flag; without it out_multi is tied low.
module encoder8_3_buffered #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  encoder8_3_buffered_if.slave  bus
);
  localparam int N = 2 ** SEL_W;

  typedef struct packed {
    logic [SEL_W-1:0] idx;
    logic             hit;
    logic             multi;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t enc;
  logic   in_ready_c, out_valid_c;
  logic   push, pop;

`ifdef ENC_MULTIHOT_CHECK_EN
  logic [SEL_W:0] ones;
`endif

  // Encode the incoming vector before it is stored; later (higher) bits override.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_vec[i]) begin
        enc.idx = SEL_W'(N - 1 - i);
        enc.hit = 1'b1;
      end
    end
`ifdef ENC_MULTIHOT_CHECK_EN
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + (SEL_W+1)'(bus.in_vec[i]);
    end
    enc.multi = (ones > (SEL_W+1)'(1));
`endif
  end

  assign push = bus.in_valid & in_ready_c;
  assign pop  = out_valid_c & bus.out_ready;

  // State register and entry storage; reset drops any buffered entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next state and next storage contents. A head that becomes invalid is
  // zeroed so the registered outputs read 0 while out_valid is low.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = enc;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = enc;
        end else if (push) begin
          state_d = FULL;
          tail_d  = enc;
        end else if (pop) begin
          state_d = EMPTY;
          head_d  = '0;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready_c  = (state_q != FULL) & reset_n;
    out_valid_c = (state_q != EMPTY);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_idx   = head_q.idx;
  assign bus.out_hit   = head_q.hit;
`ifdef ENC_MULTIHOT_CHECK_EN
  assign bus.out_multi = head_q.multi;
`else
  assign bus.out_multi = 1'b0;
`endif
endmodule

// File: tb/tb_encoder8_3_buffered.sv
// Bench for encoder8_3_buffered: directed scenarios then random traffic,
// all checked against a queue-based model of a 2-deep buffer of encodings.
module tb_encoder8_3_buffered;
  localparam int SEL_W = 3;
  localparam int N     = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  encoder8_3_buffered_if #(.SEL_W(SEL_W)) bus ();
  encoder8_3_buffered #(.SEL_W(SEL_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int idx;
    int hit;
    int multi;
  } ent_t;

  ent_t mq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  // Reference encoding from plain arithmetic: highest set bit h = clog2(v+1)-1.
  function automatic ent_t ref_enc(input int v);
    ent_t e;
    int   h;
    e.idx = 0; e.hit = 0; e.multi = 0;
    if (v != 0) begin
      h     = $clog2(v + 1) - 1;
      e.idx = (N - 1) - h;
      e.hit = 1;
`ifdef ENC_MULTIHOT_CHECK_EN
      e.multi = ($countones(v) > 1) ? 1 : 0;
`endif
    end
    return e;
  endfunction

  // One cycle: drive at negedge, check registered outputs against the model,
  // then advance the model on the following posedge.
  task automatic step(input string tag, input bit v, input logic [7:0] vec, input bit r);
    bit   push, pop;
    ent_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_vec    = vec;
    bus.out_ready = r;
    #1;
    chk({tag, ".in_ready"},  int'(bus.in_ready),  (mq.size() < 2) ? 1 : 0);
    chk({tag, ".out_valid"}, int'(bus.out_valid), (mq.size() > 0) ? 1 : 0);
    if (mq.size() > 0) e = mq[0];
    else begin e.idx = 0; e.hit = 0; e.multi = 0; end
    chk({tag, ".out_idx"},   int'(bus.out_idx),   e.idx);
    chk({tag, ".out_hit"},   int'(bus.out_hit),   e.hit);
    chk({tag, ".out_multi"}, int'(bus.out_multi), e.multi);
    push = v && (mq.size() < 2);
    pop  = (mq.size() > 0) && r;
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(ref_enc(int'(vec)));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] rv;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  int'(bus.in_ready),  0);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.out_idx",   int'(bus.out_idx),   0);
    chk("rst.out_hit",   int'(bus.out_hit),   0);
    chk("rst.out_multi", int'(bus.out_multi), 0);
    reset_n = 1'b1;

    // MSB maps to code 0, one cycle latency
    step("t1", 1'b1, 8'h80, 1'b1);
    step("t1", 1'b0, 8'h00, 1'b1);
    idle(1);

    // one-hot sweep, back-to-back
    for (int i = 0; i < N; i++) step("t2", 1'b1, 8'(1 << i), 1'b1);
    idle(2);

    // backpressure: fill, stall, drain in order
    step("t3", 1'b1, 8'h01, 1'b0);
    step("t3", 1'b1, 8'h04, 1'b0);
    step("t3", 1'b1, 8'h10, 1'b0);
    step("t3", 1'b1, 8'h10, 1'b0);
    step("t3", 1'b1, 8'h10, 1'b1);
    step("t3", 1'b1, 8'h10, 1'b1);
    step("t3", 1'b0, 8'h00, 1'b1);
    idle(2);

    // zero vector and multi-hot vector
    step("t4", 1'b1, 8'h00, 1'b1);
    step("t4", 1'b1, 8'h24, 1'b1);
    idle(2);

    // simultaneous push and pop in ONE
    step("t5", 1'b1, 8'h01, 1'b0);
    step("t5", 1'b1, 8'h02, 1'b1);
    step("t5", 1'b0, 8'h00, 1'b0);
    idle(2);

    // async reset while FULL
    step("t6", 1'b1, 8'h01, 1'b0);
    step("t6", 1'b1, 8'h02, 1'b0);
    #2;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("t6.async_out_valid", int'(bus.out_valid), 0);
    chk("t6.async_in_ready",  int'(bus.in_ready),  0);
    chk("t6.async_out_idx",   int'(bus.out_idx),   0);
    chk("t6.async_out_hit",   int'(bus.out_hit),   0);
    mq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // random traffic: mix of zero, one-hot and arbitrary vectors
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       rv = 8'h00;
        1:       rv = 8'(1 << $urandom_range(0, 7));
        default: rv = 8'($urandom_range(0, 255));
      endcase
      step("rnd", 1'($urandom_range(0, 1)), rv, ($urandom_range(0, 3) != 0));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
